// File: rtl/mat_drain.sv
`default_nettype none
// ============================================================================
// Module   : mat_drain
// Purpose  : Drains a num_i x num_j result matrix C from vector memory in
//            row-major order and presents it as a valid/ready word stream.
//            Reads are throttled so that words already buffered plus reads
//            still in flight never exceed the DEPTH-word skid FIFO.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH      skid-FIFO depth in words (power of two, >= 2)
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   start      begin a drain (sampled in IDLE only)
//   addrM3     byte base address of C (latched at start)
//   num_i      row count of C (latched at start)
//   num_j      column count of C (latched at start)
//   mem_rd     memory read request
//   mem_addr   memory read byte address
//   mem_rdata  memory read data, one cycle after mem_rd
//   out_valid  stream word available
//   out_data   stream word
//   out_last   stream end marker (final element, or row end, see below)
//   out_ready  stream consumer accept
//   busy       drain in progress (RUN or FLUSH)
//   done       one-cycle completion pulse
// Build option
//   MAT_DRAIN_ROWLAST_EN  when defined, out_last marks the last element of
//                         every row; otherwise only the final element.
// ============================================================================
module mat_drain #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addrM3,
  input  logic [31:0] num_i,
  input  logic [31:0] num_j,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Issue side
  logic [31:0] r_addr;
  logic [63:0] r_left;          // reads still to be issued
  logic        r_rd_pending;    // a read was issued last cycle
  logic        r_rd_last;
  logic        r_rd_final;
  logic        w_issue_last;
  logic        w_issue_final;
  logic        w_space;
  logic [31:0] w_used;
  logic [31:0] w_limit;

  // Skid FIFO: each entry carries {final, last, data}
  logic [33:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [33:0]   w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_head_final;

`ifdef MAT_DRAIN_ROWLAST_EN
  logic [31:0] r_j;
  logic [31:0] r_num_j;
  assign w_issue_last = (r_j == (r_num_j - 32'd1));
`else
  assign w_issue_last = w_issue_final;
`endif

  assign w_issue_final = (r_left == 64'd1);

  assign w_push       = r_rd_pending;
  assign w_pop        = out_valid && out_ready;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_final = w_head[33];

  assign out_valid = (r_count != '0);
  // Gated so the stream outputs read 0 whenever nothing is presented.
  assign out_data  = out_valid ? w_head[31:0] : 32'd0;
  assign out_last  = out_valid ? w_head[32]   : 1'b0;

  assign mem_addr = r_addr;

  // Credit check. A word popped this cycle frees its slot at the same edge
  // the new read's data could land, so the pop counts as space. This keeps
  // one read per cycle with DEPTH=2 while the post-edge total of buffered
  // plus in-flight words still never exceeds DEPTH.
  assign w_used  = 32'(r_count) + 32'(r_rd_pending);
  assign w_limit = 32'(DEPTH) + 32'(w_pop);
  assign w_space = (w_used < w_limit);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    mem_rd = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((num_i != 32'd0) && (num_j != 32'd0)) begin
            w_next = S_RUN;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        mem_rd = w_space;
        if (w_space && w_issue_final) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (w_pop && w_head_final) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address walk and read tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr       <= 32'd0;
      r_left       <= 64'd0;
      r_rd_pending <= 1'b0;
      r_rd_last    <= 1'b0;
      r_rd_final   <= 1'b0;
`ifdef MAT_DRAIN_ROWLAST_EN
      r_j          <= 32'd0;
      r_num_j      <= 32'd0;
`endif
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_addr  <= addrM3;
        r_left  <= 64'(num_i) * 64'(num_j);
`ifdef MAT_DRAIN_ROWLAST_EN
        r_j     <= 32'd0;
        r_num_j <= num_j;
`endif
      end else if (mem_rd) begin
        r_addr <= r_addr + 32'd4;
        r_left <= r_left - 64'd1;
`ifdef MAT_DRAIN_ROWLAST_EN
        r_j    <= w_issue_last ? 32'd0 : (r_j + 32'd1);
`endif
      end
      // Tags travel with the read so they line up with mem_rdata next cycle.
      r_rd_pending <= mem_rd;
      r_rd_last    <= mem_rd && w_issue_last;
      r_rd_final   <= mem_rd && w_issue_final;
    end
  end

  // --------------------------------------------------------------------------
  // Skid FIFO control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_rd_final, r_rd_last, mem_rdata};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mat_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_drain
// Purpose  : Directed self-checking bench for mat_drain with a one-cycle
//            latency memory model and a stream scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_drain;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] addrM3;
  logic [31:0] num_i;
  logic [31:0] num_j;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard state
  logic [31:0] g_base;
  logic [31:0] g_nj;
  logic [63:0] g_total;
  logic [63:0] g_rd;
  logic [63:0] g_beat;
  logic [63:0] g_iss;
  logic [63:0] g_acc;
  logic [63:0] g_cyc;
  logic [63:0] g_last_cyc;
  logic [63:0] g_done_cyc;
  int          g_done_cnt;
  logic        g_prev_stall;
  logic [31:0] g_prev_data;
  logic        g_prev_last;
  logic        ready_mode;
  int          r_ph;

  mat_drain #(.DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addrM3    (addrM3),
    .num_i     (num_i),
    .num_j     (num_j),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic exp_last(input logic [63:0] k);
`ifdef MAT_DRAIN_ROWLAST_EN
    return ((k % 64'(g_nj)) == (64'(g_nj) - 64'd1));
`else
    return (k == (g_total - 64'd1));
`endif
  endfunction

  task automatic clear_sb(input logic [31:0] base, input logic [31:0] ni, input logic [31:0] nj);
    g_base       = base;
    g_nj         = nj;
    g_total      = 64'(ni) * 64'(nj);
    g_rd         = 64'd0;
    g_beat       = 64'd0;
    g_iss        = 64'd0;
    g_acc        = 64'd0;
    g_done_cnt   = 0;
    g_prev_stall = 1'b0;
    g_last_cyc   = 64'd0;
    g_done_cyc   = 64'd0;
  endtask

  // Memory model: data valid exactly one cycle after the request; garbage otherwise.
  initial mem_rdata = 32'd0;
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mdat(mem_addr);
    else        mem_rdata <= 32'hBAD0_BAD0;
  end

  always @(posedge clk) g_cyc <= g_cyc + 64'd1;

  // Consumer: always ready, or the repeating pattern 1,0,0.
  initial begin
    out_ready = 1'b1;
    r_ph      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) begin
        out_ready = (r_ph == 0);
        r_ph      = (r_ph == 2) ? 0 : r_ph + 1;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (mem_rd) begin
        if (g_rd < g_total) check("rd_addr", 64'(mem_addr), 64'(g_base + (g_rd[31:0] << 2)));
        else                check("rd_extra", 64'd1, 64'd0);
        check("outstanding_le_depth",
              64'((g_iss + 64'd1 - g_acc - 64'(out_valid && out_ready)) <= 64'(DEPTH)), 64'd1);
        g_rd  = g_rd + 64'd1;
        g_iss = g_iss + 64'd1;
      end
      if (g_prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data",  64'(out_data),  64'(g_prev_data));
        check("hold_last",  64'(out_last),  64'(g_prev_last));
      end
      g_prev_stall = out_valid && !out_ready;
      g_prev_data  = out_data;
      g_prev_last  = out_last;
      if (out_valid && out_ready) begin
        if (g_beat < g_total) begin
          check("beat_data", 64'(out_data), 64'(mdat(g_base + (g_beat[31:0] << 2))));
          check("beat_last", 64'(out_last), 64'(exp_last(g_beat)));
        end else begin
          check("beat_extra", 64'd1, 64'd0);
        end
        g_beat = g_beat + 64'd1;
        g_acc  = g_acc + 64'd1;
        if (g_beat == g_total) g_last_cyc = g_cyc;
      end
      if (done) begin
        g_done_cnt = g_done_cnt + 1;
        g_done_cyc = g_cyc;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_rd"},    64'(mem_rd),    64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"},  64'(out_data),  64'd0);
    check({tag, "_out_last"},  64'(out_last),  64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
  endtask

  task automatic drain(input logic [31:0] base, input logic [31:0] ni, input logic [31:0] nj,
                       input logic stall, input logic extra_start, input logic lat);
    ready_mode = stall;
    @(negedge clk);
    clear_sb(base, ni, nj);
    addrM3 = base;
    num_i  = ni;
    num_j  = nj;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    addrM3 = 32'hDEAD_0000;   // shape/base must have been latched
    num_i  = 32'd7;
    num_j  = 32'd7;
    if (lat) begin
      check("lat_rd0",   64'(mem_rd),    64'd1);
      check("lat_addr0", 64'(mem_addr),  64'(base));
      check("lat_busy",  64'(busy),      64'd1);
      check("lat_val0",  64'(out_valid), 64'd0);
      for (int k = 1; k < 6; k++) begin
        @(posedge clk);
        #1;
        check("seq_rd",   64'(mem_rd),   64'd1);
        check("seq_addr", 64'(mem_addr), 64'(base + 32'(k * 4)));
        if (k == 1) check("lat_val1", 64'(out_valid), 64'd0);
        if (k == 2) check("lat_val2", 64'(out_valid), 64'd1);
      end
      @(posedge clk);
      #1;
      check("flush_no_rd", 64'(mem_rd), 64'd0);
    end
    if (extra_start) begin
      repeat (3) @(posedge clk);
      #1;
      check("extra_in_run", 64'(busy), 64'd1);
      start  = 1'b1;
      addrM3 = 32'h0000_0F00;
      num_i  = 32'd1;
      num_j  = 32'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int c = 0; c < 500; c++) begin
      if (g_done_cnt != 0) break;
      @(posedge clk);
    end
    check("done_seen", 64'(g_done_cnt != 0), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("beat_count",      g_beat,               g_total);
    check("rd_count",        g_rd,                 g_total);
    check("done_count",      64'(g_done_cnt),      64'd1);
    check("done_after_last", g_done_cyc - g_last_cyc, 64'd1);
    check("busy_after",      64'(busy),            64'd0);
    ready_mode = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    addrM3     = 32'd0;
    num_i      = 32'd0;
    num_j      = 32'd0;
    ready_mode = 1'b0;
    g_cyc      = 64'd0;
    clear_sb(32'd0, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // 2x3, always ready, cycle-exact latency and address sequence
    drain(32'h0000_0100, 32'd2, 32'd3, 1'b0, 1'b0, 1'b1);

    // 2x3 with consumer stalls
    drain(32'h0000_0300, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0);

    // Zero dimension: straight to DONE
    @(negedge clk);
    clear_sb(32'h0000_0700, 32'd0, 32'd5);
    addrM3 = 32'h0000_0700;
    num_i  = 32'd0;
    num_j  = 32'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("zero_done",  64'(done),      64'd1);
    check("zero_busy",  64'(busy),      64'd0);
    check("zero_rd",    64'(mem_rd),    64'd0);
    check("zero_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("zero_done_off", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_reads", g_rd,   64'd0);
    check("zero_beats", g_beat, 64'd0);

    // Reset in the middle of a 4x4 drain
    @(negedge clk);
    clear_sb(32'h0000_0400, 32'd4, 32'd4);
    addrM3 = 32'h0000_0400;
    num_i  = 32'd4;
    num_j  = 32'd4;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (g_beat >= 64'd2) break;
      @(posedge clk);
    end
    check("mid_reached_beat2", 64'(g_beat >= 64'd2), 64'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_sb(32'd0, 32'd0, 32'd0);
    reset = 1'b1;

    // 1x1 after reset
    drain(32'h0000_0200, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);

    // 3x3 with a start pulse during RUN
    drain(32'h0000_0500, 32'd3, 32'd3, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
